fir_filter_tdm: RTL

Parametrised, time-multiplexed FIR filter with an NUM_TAPS-deep history and one shared multiply-accumulate unit. Samples arrive on an AXI-Stream slave and filtered results leave on an AXI-Stream master, with full backpressure and tlast passthrough. Coefficients sit in a runtime-writable register file rather than on per-tap input ports. Output stage applies rounding and saturation. It is the drop-in successor to the fixed 31-tap parallel filter for low-rate channels where one multiplier is sufficient.

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_round_sat.sv | 45 ++++
 rtl/fir_filter_tdm.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// fir_pkg
// Shared definitions for the time-multiplexed FIR filter:
//   state_t   - controller state encoding (IDLE / MAC / OUT)
//   Q15_SHIFT - default output shift for Q15 coefficients
//   clog2     - constant-foldable ceiling log2 used for address widths
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int Q15_SHIFT = 15;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat
// Combinational output stage: round half toward +inf, arithmetic shift right
// by OUT_SHIFT, then clamp to the signed OUTPUT_WIDTH range.
// Ports:
//   acc    in  ACC_WIDTH     signed accumulator value
//   result out OUTPUT_WIDTH  rounded, shifted, saturated value
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_WIDTH    = 40,
  parameter int OUTPUT_WIDTH = 16,
  parameter int OUT_SHIFT    = Q15_SHIFT
) (
  input  logic signed [ACC_WIDTH-1:0]    acc,
  output logic signed [OUTPUT_WIDTH-1:0] result
);

  // One guard bit so the rounding add can never wrap.
  localparam int HALF_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic [ACC_WIDTH:0] ONE = 1;
  localparam logic signed [ACC_WIDTH:0] HALF =
    (OUT_SHIFT > 0) ? signed'(ONE << HALF_POS) : '0;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH + 2 - OUTPUT_WIDTH){1'b0}}, {(OUTPUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH + 2 - OUTPUT_WIDTH){1'b1}}, {(OUTPUT_WIDTH - 1){1'b0}}};

  logic signed [ACC_WIDTH:0] acc_ext;
  logic signed [ACC_WIDTH:0] sum;
  logic signed [ACC_WIDTH:0] rounded;

  assign acc_ext = {acc[ACC_WIDTH-1], acc};
  assign sum     = acc_ext + HALF;
  assign rounded = sum >>> OUT_SHIFT;

  always_comb begin
    result = rounded[OUTPUT_WIDTH-1:0];
    if (rounded > SAT_MAX) begin
      result = SAT_MAX[OUTPUT_WIDTH-1:0];
    end else if (rounded < SAT_MIN) begin
      result = SAT_MIN[OUTPUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fir_filter_tdm.sv
// fir_filter_tdm
// Time-multiplexed FIR filter: NUM_TAPS-deep circular history, a single
// multiply-accumulate unit stepping through one tap per cycle, and a
// runtime-writable coefficient file.
// Ports:
//   aclk, rst_i            clock, synchronous active-high reset
//   s_axis_*               AXI-Stream sample input (tdata, tvalid, tlast, tready)
//   m_axis_*               AXI-Stream result output (tdata, tvalid, tlast, tready)
//   coeff_wr_en/addr/data  coefficient write port, coeff_wr_ready = accepted
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes accepted
// MAC   | accumulating b[k]*x[n-k], one tap per cycle, N cycles
// OUT   | result held on the master port until downstream accepts it
module fir_filter_tdm
  import fir_pkg::*;
#(
  parameter int NUM_TAPS     = 31,
  parameter int COEFF_WIDTH  = 16,
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 16,
  parameter int ACC_WIDTH    = 40,
  parameter int OUT_SHIFT    = Q15_SHIFT
) (
  input  logic                             aclk,
  input  logic                             rst_i,
  input  logic signed [INPUT_WIDTH-1:0]    s_axis_tdata,
  input  logic                             s_axis_tvalid,
  input  logic                             s_axis_tlast,
  output logic                             s_axis_tready,
  output logic signed [OUTPUT_WIDTH-1:0]   m_axis_tdata,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  input  logic                             coeff_wr_en,
  input  logic [clog2(NUM_TAPS)-1:0]       coeff_wr_addr,
  input  logic signed [COEFF_WIDTH-1:0]    coeff_wr_data,
  output logic                             coeff_wr_ready
);

  localparam int AW = clog2(NUM_TAPS);
  localparam int PW = COEFF_WIDTH + INPUT_WIDTH;
  localparam logic [AW-1:0] LAST_TAP = AW'(NUM_TAPS - 1);

  if (NUM_TAPS < 2) begin : g_taps_check
    $error("fir_filter_tdm: NUM_TAPS must be at least 2");
  end
  if (ACC_WIDTH < PW + AW) begin : g_acc_check
    $error("fir_filter_tdm: ACC_WIDTH too narrow for NUM_TAPS full-width products");
  end

  state_t state, state_nx;

  logic signed [INPUT_WIDTH-1:0]  hist  [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0]  coeff [NUM_TAPS];
  logic [AW-1:0]                  wptr;
  logic [AW-1:0]                  tap;
  logic [AW-1:0]                  rd_base;
  logic [AW-1:0]                  rd_idx;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [ACC_WIDTH-1:0]    acc_sum;
  logic signed [PW-1:0]           coeff_ext;
  logic signed [PW-1:0]           sample_ext;
  logic signed [PW-1:0]           prod;
  logic signed [OUTPUT_WIDTH-1:0] result;
  logic                           last_q;

  always_ff @(posedge aclk) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    s_axis_tready  = 1'b0;
    coeff_wr_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        s_axis_tready  = 1'b1;
        coeff_wr_ready = 1'b1;
        if (s_axis_tvalid) state_nx = ST_MAC;
      end
      ST_MAC: begin
        if (tap == LAST_TAP) state_nx = ST_OUT;
      end
      ST_OUT: begin
        if (m_axis_tready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // x[n-k] lives at (wptr - k) mod N; when the AW-bit difference goes
  // negative, adding N modulo 2^AW lands back in 0..N-1.
  always_comb begin
    rd_base = wptr - tap;
    rd_idx  = (tap > wptr) ? rd_base + AW'(NUM_TAPS) : rd_base;
  end

  always_comb begin
    coeff_ext  = {{INPUT_WIDTH{coeff[tap][COEFF_WIDTH-1]}}, coeff[tap]};
    sample_ext = {{COEFF_WIDTH{hist[rd_idx][INPUT_WIDTH-1]}}, hist[rd_idx]};
    prod       = coeff_ext * sample_ext;
    acc_sum    = acc + {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
  end

  // Fed with acc_sum so the last tap's product is included on the OUT entry edge.
  fir_round_sat #(
    .ACC_WIDTH   (ACC_WIDTH),
    .OUTPUT_WIDTH(OUTPUT_WIDTH),
    .OUT_SHIFT   (OUT_SHIFT)
  ) u_round_sat (
    .acc   (acc_sum),
    .result(result)
  );

  always_ff @(posedge aclk) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        hist[i]  <= '0;
        coeff[i] <= '0;
      end
      wptr          <= '0;
      tap           <= '0;
      acc           <= '0;
      last_q        <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (coeff_wr_en && coeff_wr_ready && (int'(coeff_wr_addr) < NUM_TAPS)) begin
        coeff[coeff_wr_addr] <= coeff_wr_data;
      end
      case (state)
        ST_IDLE: begin
          if (s_axis_tvalid) begin
            hist[wptr] <= s_axis_tdata;
            last_q     <= s_axis_tlast;
            tap        <= '0;
            acc        <= '0;
          end
        end
        ST_MAC: begin
          acc <= acc_sum;
          if (tap == LAST_TAP) begin
            tap           <= '0;
            m_axis_tdata  <= result;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= last_q;
          end else begin
            tap <= tap + AW'(1);
          end
        end
        ST_OUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            wptr          <= (wptr == LAST_TAP) ? '0 : wptr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
